alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one 2-bit-operand ALU (add/sub/mul/div) between NUM_REQ requesters.
//  Round-robin arbitration; valid/ready on the request side and the response side.
//  Sequences each operation through a fixed-latency execute phase.
//  Returns the 4-bit result tagged with the requester id.
// PARAMETERS
//  NUM_REQ  4  number of requesters, 2..4
//  ID_W     2  width of rsp_id; must satisfy 2**ID_W >= NUM_REQ
//  LAT      1  execute-phase cycles, 1..15
// PORTS
//  clk         in   1          rising-edge clock; the only clock
//  rst         in   1          synchronous, active-high reset
//  req_valid   in   NUM_REQ    per-requester request valid
//  req_ready   out  NUM_REQ    one-hot grant/accept; at most one bit high
//  req_code    in   3*NUM_REQ  opcode of requester i at [3i+2:3i]; 1=add 2=sub 3=mul 4=div
//  req_a       in   2*NUM_REQ  operand a of requester i at [2i+1:2i], unsigned
//  req_b       in   2*NUM_REQ  operand b of requester i at [2i+1:2i], unsigned
//  rsp_valid   out  1          response valid
//  rsp_ready   in   1          response accept
//  rsp_id      out  ID_W       index of the requester that owns the response
//  rsp_result  out  4          result
//  rsp_err     out  1          illegal opcode or divide by zero
//  busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: the following values hold in the cycle after rst is sampled high.
//   - state=IDLE, rr_ptr=0, req_ready=0.
//   - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
//   - rst during EXEC or RESP discards the in-flight operation; no response is produced.
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE: grant g is the first asserted req_valid, searching from rr_ptr upward modulo NUM_REQ.
//   - IDLE: req_ready[g] is driven combinationally, only in IDLE.
//   - IDLE: on handshake, latch code/a/b/id, set rr_ptr=(g+1)%NUM_REQ, load cnt=LAT-1, go to EXEC.
//   - IDLE: with no req_valid asserted, remain in IDLE and leave rr_ptr unchanged.
//   - EXEC: cnt decrements each cycle; when cnt==0, register the alu_core outputs and go to RESP.
//   - RESP: rsp_valid=1 and rsp_* are held stable until rsp_ready is sampled high.
//   - RESP: on rsp_ready, go to IDLE and drop rsp_valid in the next cycle.
//  Latency: from request handshake edge to first rsp_valid cycle is LAT+1 clocks.
//  Minimum spacing between request handshakes is LAT+2 clocks with rsp_ready tied high.
//  Requests: req_ready=0 outside IDLE.
//   - A requester holds valid and its fields stable until it sees ready.
//   - Withdrawing valid before ready is tolerated: no grant is issued to that requester.
//  Arithmetic, with all results 4 bits:
//   - add: a+b, range 0..6.
//   - sub: (a-b) mod 16, two's complement; 0-3 gives 4'hD.
//   - mul: a*b, range 0..9.
//   - div: floor(a/b).
//   - div with b=0: result=4'hF, err=1.
//   - opcode 0 or 5..7: result=0, err=1.
//  Fairness: with all requesters continuously valid, grants run 0,1,..,NUM_REQ-1,0,...
// STRUCTURE
//  Shared package alu_pkg:
//   - opcode localparams OP_ADD=3'd1, OP_SUB=3'd2, OP_MUL=3'd3, OP_DIV=3'd4.
//   - FSM state encodings ST_IDLE, ST_EXEC, ST_RESP.
//   - DIV0_RESULT=4'hF.
//  Sub-module alu_core: purely combinational (code, a, b) -> (result[3:0], err).
//  Arbiter, counter and FSM live in alu_arbiter.
// TESTING
//  Single request: rst, then req0 code=1 a=3 b=2 -> ready0 for 1 cycle; rsp id=0 result=5 err=0 after LAT+1.
//  Sub wrap and mul: req1 code=2 a=0 b=3 -> result=4'hD; then req1 code=3 a=3 b=3 -> result=9.
//  Error paths: code=4 a=3 b=0 -> result=F err=1; code=4 a=3 b=2 -> result=1 err=0; code=6 -> result=0 err=1.
//  Round robin: all 4 valid, rsp_ready=1 -> grant order 0,1,2,3,0; spacing LAT+2 clocks.
//  Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready all 0; release -> IDLE, next grant.
//  Reset mid-operation: rst asserted in EXEC -> no rsp_valid, next cycle busy=0; next grant starts from req0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encodings and constants for the ALU arbiter
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] DIV0_RESULT = 4'hF;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 2-bit-operand ALU with 4-bit result and error flag
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0] code,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] result,
  output logic       err
);

  logic [3:0] a_x;
  logic [3:0] b_x;

  assign a_x = {2'b00, a};
  assign b_x = {2'b00, b};

  always_comb begin
    result = 4'h0;
    err    = 1'b0;
    case (code)
      OP_ADD: result = a_x + b_x;
      OP_SUB: result = a_x - b_x;
      OP_MUL: result = a_x * b_x;
      OP_DIV: begin
        if (b == 2'd0) begin
          result = DIV0_RESULT;
          err    = 1'b1;
        end else begin
          result = a_x / b_x;
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one alu_core among NUM_REQ requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_code,
  input  logic [2*NUM_REQ-1:0] req_a,
  input  logic [2*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_result,
  output logic                 rsp_err,
  output logic                 busy
);

  logic [1:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [3:0]      cnt;
  logic [2:0]      op_code;
  logic [1:0]      op_a;
  logic [1:0]      op_b;
  logic [ID_W-1:0] op_id;

  logic            found;
  int              gnt;
  logic [2:0]      sel_code;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  logic [3:0]      core_result;
  logic            core_err;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    gnt   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == (int'(rr_ptr) + k) % NUM_REQ) && req_valid[i]) begin
          found = 1'b1;
          gnt   = i;
        end
      end
    end
  end

  always_comb begin
    sel_code = 3'd0;
    sel_a    = 2'd0;
    sel_b    = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == i) begin
        sel_code = req_code[3*i +: 3];
        sel_a    = req_a[2*i +: 2];
        sel_b    = req_b[2*i +: 2];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == ST_IDLE) && found && (gnt == i);
    end
  end

  assign busy = (state != ST_IDLE);

  alu_core u_core (
    .code   (op_code),
    .a      (op_a),
    .b      (op_b),
    .result (core_result),
    .err    (core_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      cnt        <= 4'd0;
      op_code    <= 3'd0;
      op_a       <= 2'd0;
      op_b       <= 2'd0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= 4'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A grant is only offered to a valid requester, so found implies handshake.
          if (found) begin
            op_code <= sel_code;
            op_a    <= sel_a;
            op_b    <= sel_b;
            op_id   <= ID_W'(gnt);
            rr_ptr  <= ID_W'((gnt + 1) % NUM_REQ);
            cnt     <= 4'(LAT - 1);
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == 4'd0) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= op_id;
            rsp_result <= core_result;
            rsp_err    <= core_err;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (NUM_REQ=4, LAT=1)
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_code;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(4), .ID_W(2), .LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_code   (req_code),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Stimulus only: issue one request, return handshake-to-response latency and the response.
  task automatic run_op(input int i, input logic [2:0] code, input logic [1:0] a, input logic [1:0] b,
                        output int lat, output logic [1:0] id, output logic [3:0] res, output logic err);
    int n;
    req_code[3*i +: 3] = code;
    req_a[2*i +: 2] = a;
    req_b[2*i +: 2] = b;
    req_valid[i] = 1'b1;
    lat = -1;
    n = 0;
    #1;
    while (req_ready[i] !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready[i] === 1'b1) begin
      @(negedge clk);
      req_valid[i] = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
    end
    req_valid[i] = 1'b0;
    id = rsp_id;
    res = rsp_result;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 4'd0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp: valid=%b id=%0d result=%h err=%b, want 0 0 0 0", rsp_valid, rsp_id, rsp_result, rsp_err);
    end
    tests++;
    if (busy !== 1'b0 || req_ready !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b req_ready=%b, want 0 0000", busy, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int lat; logic [1:0] id; logic [3:0] res; logic err;
    run_op(0, 3'd1, 2'd3, 2'd2, lat, id, res, err);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL single_latency: got %0d, want 2", lat); end
    tests++;
    if (id !== 2'd0 || res !== 4'd5 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_add: id=%0d result=%h err=%b, want 0 5 0", id, res, err);
    end
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_return_idle: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_sub_mul();
    int lat; logic [1:0] id; logic [3:0] res; logic err;
    run_op(1, 3'd2, 2'd0, 2'd3, lat, id, res, err);
    tests++;
    if (lat !== 2 || id !== 2'd1 || res !== 4'hD || err !== 1'b0) begin
      fails++;
      $display("FAIL sub_wrap: lat=%0d id=%0d result=%h err=%b, want 2 1 d 0", lat, id, res, err);
    end
    run_op(1, 3'd3, 2'd3, 2'd3, lat, id, res, err);
    tests++;
    if (lat !== 2 || id !== 2'd1 || res !== 4'd9 || err !== 1'b0) begin
      fails++;
      $display("FAIL mul_max: lat=%0d id=%0d result=%h err=%b, want 2 1 9 0", lat, id, res, err);
    end
  endtask

  task automatic test_errors();
    int lat; logic [1:0] id; logic [3:0] res; logic err;
    run_op(2, 3'd4, 2'd3, 2'd0, lat, id, res, err);
    tests++;
    if (id !== 2'd2 || res !== 4'hF || err !== 1'b1) begin
      fails++;
      $display("FAIL div_zero: id=%0d result=%h err=%b, want 2 f 1", id, res, err);
    end
    run_op(2, 3'd4, 2'd3, 2'd2, lat, id, res, err);
    tests++;
    if (id !== 2'd2 || res !== 4'h1 || err !== 1'b0) begin
      fails++;
      $display("FAIL div_floor: id=%0d result=%h err=%b, want 2 1 0", id, res, err);
    end
    run_op(3, 3'd6, 2'd1, 2'd1, lat, id, res, err);
    tests++;
    if (id !== 2'd3 || res !== 4'h0 || err !== 1'b1) begin
      fails++;
      $display("FAIL bad_opcode: id=%0d result=%h err=%b, want 3 0 1", id, res, err);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gmask [5];
    int         gcyc  [5];
    logic [1:0] rid   [4];
    logic [3:0] rres  [4];
    logic [3:0] exp_mask;
    int ng, nr;
    logic drop;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_code[3*i +: 3] = 3'd1;
      req_a[2*i +: 2] = 2'(i);
      req_b[2*i +: 2] = 2'd1;
    end
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    ng = 0; nr = 0; drop = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (drop) begin req_valid = 4'b0; drop = 1'b0; end
      #1;
      if (req_ready !== 4'b0 && ng < 5) begin
        gmask[ng] = req_ready;
        gcyc[ng] = cyc;
        ng++;
        if (ng == 5) drop = 1'b1;
      end
      if (rsp_valid === 1'b1 && nr < 4) begin
        rid[nr] = rsp_id;
        rres[nr] = rsp_result;
        nr++;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    tests++;
    if (ng !== 5 || nr !== 4) begin
      fails++;
      $display("FAIL rr_count: grants=%0d responses=%0d, want 5 >=4", ng, nr);
    end else begin
      for (int k = 0; k < 5; k++) begin
        exp_mask = 4'b0001 << (k % 4);
        tests++;
        if (gmask[k] !== exp_mask) begin
          fails++;
          $display("FAIL rr_grant%0d: got %b, want %b", k, gmask[k], exp_mask);
        end
        if (k > 0) begin
          tests++;
          if (gcyc[k] - gcyc[k-1] !== 3) begin
            fails++;
            $display("FAIL rr_spacing%0d: got %0d, want 3", k, gcyc[k] - gcyc[k-1]);
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (rid[k] !== 2'(k) || rres[k] !== 4'(k + 1)) begin
          fails++;
          $display("FAIL rr_rsp%0d: id=%0d result=%h, want %0d %0d", k, rid[k], rres[k], k, k + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    req_code[2:0] = 3'd3; req_a[1:0] = 2'd2; req_b[1:0] = 2'd3;
    req_code[5:3] = 3'd2; req_a[3:2] = 2'd2; req_b[3:2] = 2'd1;
    req_valid = 4'b0011;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL bp_first_grant: got %b, want 0001", req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 4'd6 || rsp_err !== 1'b0
          || req_ready !== 4'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d result=%h err=%b ready=%b busy=%b, want 1 0 6 0 0000 1",
                 c, rsp_valid, rsp_id, rsp_result, rsp_err, req_ready, busy);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL bp_release: rsp_valid=%b req_ready=%b, want 0 0010", rsp_valid, req_ready);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 4'd1) begin
      fails++;
      $display("FAIL bp_second: valid=%b id=%0d result=%h, want 1 1 1", rsp_valid, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    req_code[5:3] = 3'd1; req_a[3:2] = 2'd1; req_b[3:2] = 2'd1;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_state: rsp_valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL mid_reset_no_rsp: %0d cycles with rsp_valid, want 0", bad);
    end
    req_code[2:0] = 3'd1; req_code[8:6] = 3'd1;
    req_valid = 4'b0101;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL mid_reset_rr: got %b, want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0;
    req_code = 12'b0;
    req_a = 8'b0;
    req_b = 8'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_sub_mul();
    test_errors();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
